// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm sounder: state encoding, default
// timing constants and the LED chase seed.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BEEP_ON  = 2'd1,
        BEEP_OFF = 2'd2,
        SNOOZE   = 2'd3
    } sounder_state_t;

    localparam int DEF_ON_CYCLES     = 4;
    localparam int DEF_OFF_CYCLES    = 4;
    localparam int DEF_SNOOZE_CYCLES = 16;
    localparam int DEF_MAX_SNOOZES   = 2;

    localparam logic [7:0] LED_SEED = 8'h01;

    // Rotate the LED chase one position left; 8'h80 wraps to 8'h01.
    function automatic logic [7:0] rotl8(input logic [7:0] value);
        return {value[6:0], value[7]};
    endfunction

endpackage

// File: rtl/alarm_sounder_phase_timer.sv
// Shared 16-bit loadable down-counter timing every sounder phase.
// A phase loaded with N-1 lasts exactly N cycles; done flags count==0.
module phase_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    output logic        done
);

    logic [15:0] count;

    // Load takes precedence over counting; the count parks at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 16'd0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != 16'd0)) begin
            count <= count - 16'd1;
        end
    end

    assign done = (count == 16'd0);

endmodule

// File: rtl/alarm_sounder.sv
// Alarm sounder: turns the alarm FSM's alert level into a timed beep
// pattern with an LED chase, honouring a limited snooze budget.
// Optional macro ALARM_SOUNDER_ESCALATE_EN halves the OFF gap every
// fourth beep (floor of one cycle), restored on IDLE or SNOOZE entry.
module alarm_sounder
    import alarm_pkg::*;
#(
    parameter int ON_CYCLES     = DEF_ON_CYCLES,
    parameter int OFF_CYCLES    = DEF_OFF_CYCLES,
    parameter int SNOOZE_CYCLES = DEF_SNOOZE_CYCLES,
    parameter int MAX_SNOOZES   = DEF_MAX_SNOOZES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alert,
    input  logic       snooze,
    output logic       buzz,
    output logic [7:0] leds,
    output logic       active,
    output logic [1:0] snooze_cnt
);

    localparam logic [15:0] ON_LOAD     = 16'(ON_CYCLES - 1);
    localparam logic [15:0] OFF_FULL    = 16'(OFF_CYCLES);
    localparam logic [15:0] SNOOZE_LOAD = 16'(SNOOZE_CYCLES - 1);
    localparam logic [2:0]  MAX_SN      = 3'(MAX_SNOOZES);

    sounder_state_t state, next_state;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] off_load;
    logic        done;
    logic        snooze_take;
    logic        can_snooze;
    logic [7:0]  leds_next;

    assign can_snooze = ({1'b0, snooze_cnt} < MAX_SN);

    phase_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .en       (state != IDLE),
        .done     (done)
    );

`ifdef ALARM_SOUNDER_ESCALATE_EN
    logic [1:0]  beep_cnt;
    logic [15:0] off_eff;

    // Count beeps; on every beep that follows a completed group of four,
    // halve the OFF gap. Silence (IDLE/SNOOZE) restores the full gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            beep_cnt <= 2'd0;
            off_eff  <= OFF_FULL;
        end else if ((next_state == IDLE) || (next_state == SNOOZE)) begin
            beep_cnt <= 2'd0;
            off_eff  <= OFF_FULL;
        end else if ((next_state == BEEP_ON) && (state != BEEP_ON)) begin
            beep_cnt <= beep_cnt + 2'd1;
            if ((state == BEEP_OFF) && (beep_cnt == 2'd0) && (off_eff > 16'd1)) begin
                off_eff <= off_eff >> 1;
            end
        end
    end

    assign off_load = off_eff - 16'd1;
`else
    assign off_load = OFF_FULL - 16'd1;
`endif

    // Next-state and timer-load decode: alert low beats snooze, which
    // beats phase expiry.
    always_comb begin
        next_state  = state;
        load        = 1'b0;
        load_val    = 16'd0;
        snooze_take = 1'b0;
        if ((state != IDLE) && !alert) begin
            next_state = IDLE;
            load       = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (alert) begin
                        next_state = BEEP_ON;
                        load       = 1'b1;
                        load_val   = ON_LOAD;
                    end
                end
                BEEP_ON, BEEP_OFF: begin
                    if (snooze && can_snooze) begin
                        next_state  = SNOOZE;
                        load        = 1'b1;
                        load_val    = SNOOZE_LOAD;
                        snooze_take = 1'b1;
                    end else if (done) begin
                        next_state = (state == BEEP_ON) ? BEEP_OFF : BEEP_ON;
                        load       = 1'b1;
                        load_val   = (state == BEEP_ON) ? off_load : ON_LOAD;
                    end
                end
                SNOOZE: begin
                    if (done) begin
                        next_state = BEEP_ON;
                        load       = 1'b1;
                        load_val   = ON_LOAD;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // LED chase: seed on a fresh start, rotate on each new beep, hold
    // through the gap, dark when silent.
    always_comb begin
        leds_next = 8'h00;
        case (next_state)
            BEEP_ON: begin
                if (state == BEEP_ON) begin
                    leds_next = leds;
                end else if (state == BEEP_OFF) begin
                    leds_next = rotl8(leds);
                end else begin
                    leds_next = LED_SEED;
                end
            end
            BEEP_OFF: leds_next = leds;
            default:  leds_next = 8'h00;
        endcase
    end

    // State and registered outputs update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            buzz       <= 1'b0;
            leds       <= 8'h00;
            active     <= 1'b0;
            snooze_cnt <= 2'd0;
        end else begin
            state  <= next_state;
            buzz   <= (next_state == BEEP_ON);
            leds   <= leds_next;
            active <= (next_state != IDLE);
            if (next_state == IDLE) begin
                snooze_cnt <= 2'd0;
            end else if (snooze_take) begin
                snooze_cnt <= snooze_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_alarm_sounder.sv
// Directed bench for alarm_sounder with a scoreboard of expected outputs.
// With ALARM_SOUNDER_ESCALATE_EN defined it runs the escalation sequence.
module tb_alarm_sounder;

`ifdef ALARM_SOUNDER_ESCALATE_EN
    localparam int OFF_P = 8;
`else
    localparam int OFF_P = 4;
`endif

    logic       clk;
    logic       reset;
    logic       alert;
    logic       snooze;
    logic       buzz;
    logic [7:0] leds;
    logic       active;
    logic [1:0] snooze_cnt;

    typedef struct {
        logic       buzz;
        logic [7:0] leds;
        logic       active;
        logic [1:0] cnt;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic [7:0] led;

    alarm_sounder #(
        .ON_CYCLES     (4),
        .OFF_CYCLES    (OFF_P),
        .SNOOZE_CYCLES (16),
        .MAX_SNOOZES   (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alert      (alert),
        .snooze     (snooze),
        .buzz       (buzz),
        .leds       (leds),
        .active     (active),
        .snooze_cnt (snooze_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop the oldest expectation and compare every output field.
    task automatic check_output();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (buzz === e.buzz) else begin
            errors++;
            $error("[TB] FAIL %s buzz observed=%b expected=%b", e.tag, buzz, e.buzz);
        end
        checks++;
        assert (leds === e.leds) else begin
            errors++;
            $error("[TB] FAIL %s leds observed=%h expected=%h", e.tag, leds, e.leds);
        end
        checks++;
        assert (active === e.active) else begin
            errors++;
            $error("[TB] FAIL %s active observed=%b expected=%b", e.tag, active, e.active);
        end
        checks++;
        assert (snooze_cnt === e.cnt) else begin
            errors++;
            $error("[TB] FAIL %s snooze_cnt observed=%0d expected=%0d", e.tag, snooze_cnt, e.cnt);
        end
    endtask

    // Drive one cycle of inputs, record what the outputs must be after
    // the next edge, then check just after that edge.
    task automatic apply_stimulus(input logic r, input logic a, input logic s,
                                  input logic eb, input logic [7:0] el,
                                  input logic ea, input logic [1:0] ec,
                                  input string tag);
        exp_t e;
        reset  = r;
        alert  = a;
        snooze = s;
        e.buzz = eb;
        e.leds = el;
        e.active = ea;
        e.cnt  = ec;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_output();
    endtask

    initial begin
        $display("[TB] start, OFF_CYCLES=%0d", OFF_P);
        apply_stimulus(1, 0, 0, 0, 8'h00, 0, 0, "reset_a");
        apply_stimulus(1, 0, 0, 0, 8'h00, 0, 0, "reset_b");
        led = 8'h01;
`ifdef ALARM_SOUNDER_ESCALATE_EN
        for (int b = 0; b < 12; b++) begin
            for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 0, 1, led, 1, 0, "esc_on");
            for (int i = 0; i < ((b < 4) ? 8 : (b < 8) ? 4 : 2); i++)
                apply_stimulus(0, 1, 0, 0, led, 1, 0, "esc_gap");
            led = {led[6:0], led[7]};
        end
        apply_stimulus(0, 1, 0, 1, led, 1, 0, "esc_beep13");
        apply_stimulus(0, 1, 1, 0, 8'h00, 1, 1, "esc_snooze");
        for (int i = 0; i < 15; i++) apply_stimulus(0, 1, 0, 0, 8'h00, 1, 1, "esc_silent");
        for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 0, 1, 8'h01, 1, 1, "esc_resume_on");
        for (int i = 0; i < 8; i++) apply_stimulus(0, 1, 0, 0, 8'h01, 1, 1, "esc_gap_restored");
        apply_stimulus(0, 1, 0, 1, 8'h02, 1, 1, "esc_next_beep");
`else
        // Plain beeping: five beeps with a rotating chase.
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 0, 1, led, 1, 0, "beep_on");
            for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 0, 0, led, 1, 0, "beep_off");
            led = {led[6:0], led[7]};
        end
        apply_stimulus(0, 1, 0, 1, 8'h20, 1, 0, "beep6_on");
        apply_stimulus(0, 1, 0, 1, 8'h20, 1, 0, "beep6_on");
        apply_stimulus(0, 0, 0, 0, 8'h00, 0, 0, "alert_drop");
        apply_stimulus(0, 0, 0, 0, 8'h00, 0, 0, "idle_hold");

        // Snooze budget: two honoured, third ignored.
        for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 0, 1, 8'h01, 1, 0, "ep2_on");
        apply_stimulus(0, 1, 0, 0, 8'h01, 1, 0, "ep2_off");
        apply_stimulus(0, 1, 1, 0, 8'h00, 1, 1, "snooze1");
        for (int i = 0; i < 15; i++) apply_stimulus(0, 1, 0, 0, 8'h00, 1, 1, "snooze1_silent");
        for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 0, 1, 8'h01, 1, 1, "snooze1_expiry_on");
        apply_stimulus(0, 1, 0, 0, 8'h01, 1, 1, "ep2_off2");
        apply_stimulus(0, 1, 1, 0, 8'h00, 1, 2, "snooze2");
        for (int i = 0; i < 15; i++) apply_stimulus(0, 1, 0, 0, 8'h00, 1, 2, "snooze2_silent");
        for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 0, 1, 8'h01, 1, 2, "snooze2_expiry_on");
        apply_stimulus(0, 1, 0, 0, 8'h01, 1, 2, "ep2_off3");
        apply_stimulus(0, 1, 1, 0, 8'h01, 1, 2, "snooze3_ignored");
        for (int i = 0; i < 2; i++) apply_stimulus(0, 1, 0, 0, 8'h01, 1, 2, "ep2_off3_rest");
        apply_stimulus(0, 1, 0, 1, 8'h02, 1, 2, "beeping_continues");
        apply_stimulus(0, 0, 0, 0, 8'h00, 0, 0, "drop_clears_cnt");

        // Snooze coinciding with the last BEEP_ON cycle, then alert drop in SNOOZE.
        for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 0, 1, 8'h01, 1, 0, "ep3_on");
        apply_stimulus(0, 1, 1, 0, 8'h00, 1, 1, "snooze_at_expiry");
        for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 0, 0, 8'h00, 1, 1, "ep3_silent");
        apply_stimulus(0, 0, 0, 0, 8'h00, 0, 0, "snooze_alert_drop");

        // Reset while snoozing.
        for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 0, 1, 8'h01, 1, 0, "ep4_on");
        apply_stimulus(0, 1, 0, 0, 8'h01, 1, 0, "ep4_off");
        apply_stimulus(0, 1, 1, 0, 8'h00, 1, 1, "ep4_snooze");
        for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 0, 0, 8'h00, 1, 1, "ep4_silent");
        apply_stimulus(1, 1, 0, 0, 8'h00, 0, 0, "reset_in_snooze");
        apply_stimulus(0, 0, 0, 0, 8'h00, 0, 0, "post_reset");
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
